// File: rtl/dct2_1d_stage1_pipe.sv
// First DCT-II stage: even/odd split and odd-half products for N = 4..32.
// Valid/ready pipeline of two or three register stages selected by PIPE_MUL.
module dct2_1d_stage1_pipe #(
  parameter int IN_W     = 9,
  parameter int PIPE_MUL = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [1:0]              in_size,
  input  logic [32*IN_W-1:0]      in_x,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [1:0]              out_size,
  output logic [16*(IN_W+1)-1:0]  out_e,
  output logic [16*(IN_W+11)-1:0] out_o
);

  localparam int EW  = IN_W + 1;
  localparam int PW  = IN_W + 9;
  localparam int YW  = IN_W + 11;
  localparam int CTW = 4 * 16 * 16 * 8;

  // Magnitude of the 32-point basis at angle m*pi/64, first quadrant.
  function automatic int tmag(input int m);
    int v;
    case (m)
      1, 2, 3: v = 90;
      4:  v = 89;
      5:  v = 88;
      6:  v = 87;
      7:  v = 85;
      8:  v = 83;
      9:  v = 82;
      10: v = 80;
      11: v = 78;
      12: v = 75;
      13: v = 73;
      14: v = 70;
      15: v = 67;
      16: v = 64;
      17: v = 61;
      18: v = 57;
      19: v = 54;
      20: v = 50;
      21: v = 46;
      22: v = 43;
      23: v = 38;
      24: v = 36;
      25: v = 31;
      26: v = 25;
      27: v = 22;
      28: v = 18;
      29: v = 13;
      30: v = 9;
      31: v = 4;
      default: v = 0;
    endcase
    return v;
  endfunction

  function automatic int coef(input int r, input int i);
    int m;
    m = (r * (2 * i + 1)) % 128;
    if (m <= 32)
      return tmag(m);
    else if (m <= 64)
      return -tmag(64 - m);
    else if (m <= 96)
      return -tmag(m - 64);
    return tmag(128 - m);
  endfunction

  function automatic int lane_coef(
    input int s,
    input int k,
    input int i
  );
    int n;
    n = 4 << s;
    if (k < n / 2 && i < n / 2)
      return coef((2 * k + 1) * (32 / n), i);
    return 0;
  endfunction

  function automatic logic [CTW-1:0] build_ctab();
    logic [CTW-1:0] t;
    t = '0;
    for (int s = 0; s < 4; s++)
      for (int k = 0; k < 16; k++)
        for (int i = 0; i < 16; i++)
          t[((s*16 + k)*16 + i)*8 +: 8] = 8'(lane_coef(s, k, i));
    return t;
  endfunction

  // Lane coefficients per size; lanes outside the half are zero.
  localparam logic [CTW-1:0] CTAB = build_ctab();

  logic [5:0]           hi;
  logic [4:0]           h;
  logic [IN_W-1:0]      xa;
  logic [IN_W-1:0]      xb;
  logic signed [EW-1:0] e_d [16];
  logic signed [EW-1:0] o_d [16];

  always_comb begin
    unique case (in_size)
      2'd0: begin hi = 6'd3;  h = 5'd2;  end
      2'd1: begin hi = 6'd7;  h = 5'd4;  end
      2'd2: begin hi = 6'd15; h = 5'd8;  end
      2'd3: begin hi = 6'd31; h = 5'd16; end
    endcase
    xa = '0;
    xb = '0;
    for (int i = 0; i < 16; i++) begin
      e_d[i] = '0;
      o_d[i] = '0;
      if (5'(i) < h) begin
        xa = in_x[i*IN_W +: IN_W];
        xb = in_x[(int'(hi) - i)*IN_W +: IN_W];
        e_d[i] = $signed({xa[IN_W-1], xa}) + $signed({xb[IN_W-1], xb});
        o_d[i] = $signed({xa[IN_W-1], xa}) - $signed({xb[IN_W-1], xb});
      end
    end
  end

  logic                 rdy_a;
  logic                 rdy_c;
  logic                 va_q;
  logic [1:0]           sa_q;
  logic signed [EW-1:0] ea_q [16];
  logic signed [EW-1:0] oa_q [16];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      va_q <= 1'b0;
      sa_q <= '0;
      for (int i = 0; i < 16; i++) begin
        ea_q[i] <= '0;
        oa_q[i] <= '0;
      end
    end else if (rdy_a) begin
      va_q <= in_valid;
      if (in_valid) begin
        sa_q <= in_size;
        ea_q <= e_d;
        oa_q <= o_d;
      end
    end
  end

  logic signed [PW-1:0] p_d [16][16];

  always_comb begin
    for (int k = 0; k < 16; k++)
      for (int i = 0; i < 16; i++)
        p_d[k][i] = PW'(oa_q[i]) *
          PW'($signed(CTAB[((int'(sa_q)*16 + k)*16 + i)*8 +: 8]));
  end

  logic                 v_t;
  logic [1:0]           s_t;
  logic signed [EW-1:0] e_t [16];
  logic signed [PW-1:0] p_t [16][16];

  assign rdy_c = !out_valid || out_ready;

  if (PIPE_MUL != 0) begin : g_pipe
    logic                 vb_q;
    logic                 rdy_b;
    logic [1:0]           sb_q;
    logic signed [EW-1:0] eb_q [16];
    logic signed [PW-1:0] pb_q [16][16];

    assign rdy_b = !vb_q || rdy_c;
    assign rdy_a = !va_q || rdy_b;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vb_q <= 1'b0;
        sb_q <= '0;
        for (int k = 0; k < 16; k++) begin
          eb_q[k] <= '0;
          for (int i = 0; i < 16; i++)
            pb_q[k][i] <= '0;
        end
      end else if (rdy_b) begin
        vb_q <= va_q;
        if (va_q) begin
          sb_q <= sa_q;
          eb_q <= ea_q;
          pb_q <= p_d;
        end
      end
    end

    assign v_t = vb_q;
    assign s_t = sb_q;
    assign e_t = eb_q;
    assign p_t = pb_q;
  end else begin : g_flat
    assign rdy_a = !va_q || rdy_c;
    assign v_t   = va_q;
    assign s_t   = sa_q;
    assign e_t   = ea_q;
    assign p_t   = p_d;
  end

  logic signed [YW-1:0] acc;
  logic signed [YW-1:0] y_d [16];

  always_comb begin
    acc = '0;
    for (int k = 0; k < 16; k++) begin
      acc = '0;
      for (int i = 0; i < 16; i++)
        acc = acc + YW'(p_t[k][i]);
      y_d[k] = acc;
    end
  end

  logic                 vc_q;
  logic [1:0]           sc_q;
  logic signed [EW-1:0] ec_q [16];
  logic signed [YW-1:0] yc_q [16];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vc_q <= 1'b0;
      sc_q <= '0;
      for (int k = 0; k < 16; k++) begin
        ec_q[k] <= '0;
        yc_q[k] <= '0;
      end
    end else if (rdy_c) begin
      vc_q <= v_t;
      if (v_t) begin
        sc_q <= s_t;
        ec_q <= e_t;
        yc_q <= y_d;
      end
    end
  end

  for (genvar g = 0; g < 16; g++) begin : g_out
    assign out_e[g*EW +: EW] = ec_q[g];
    assign out_o[g*YW +: YW] = yc_q[g];
  end

  assign out_valid = vc_q;
  assign out_size  = sc_q;
  assign in_ready  = rdy_a;

endmodule

// File: tb/tb_dct2_1d_stage1_pipe.sv
// Bench for dct2_1d_stage1_pipe: directed rows, backpressure, reset and
// a randomized scoreboard run against an independent integer model.
module tb_dct2_1d_stage1_pipe;

  localparam int IN_W = 9;
  localparam int EW   = IN_W + 1;
  localparam int YW   = IN_W + 11;

  localparam int A32 [16] = '{90, 90, 88, 85, 82, 78, 73, 67,
                              61, 54, 46, 38, 31, 22, 13, 4};
  localparam int A16 [8]  = '{90, 87, 80, 70, 57, 43, 25, 9};
  localparam int A8 [4]   = '{89, 75, 50, 18};
  localparam int A4 [2]   = '{83, 36};

  logic                 clk;
  logic                 rst_n;
  logic                 in_valid;
  logic                 in_ready;
  logic [1:0]           in_size;
  logic [32*IN_W-1:0]   in_x;
  logic                 out_valid;
  logic                 out_ready;
  logic [1:0]           out_size;
  logic [16*EW-1:0]     out_e;
  logic [16*YW-1:0]     out_o;

  dct2_1d_stage1_pipe #(.IN_W(IN_W), .PIPE_MUL(1)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_size(in_size),
    .in_x(in_x),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_size(out_size),
    .out_e(out_e),
    .out_o(out_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]       s;
    logic [16*EW-1:0] e;
    logic [16*YW-1:0] o;
  } exp_t;

  exp_t scb [$];
  int   pop_cyc [$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_pop   = 0;
  int   cyc     = 0;
  bit   rand_bp = 1'b0;
  exp_t mon_ex;

  logic [16*YW-1:0] hold_o;
  logic [16*EW-1:0] hold_e;
  logic [1:0]       hold_s;
  int               bp_t;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk_i(input string tag, input int obs, input int expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic chk_v(input string tag, input logic [511:0] obs,
                       input logic [511:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Magnitudes come from the anchor lists; the sign from the cosine itself.
  function automatic int tcoef(input int n, input int k, input int i);
    int m, mm, mag;
    real c;
    m  = ((2 * k + 1) * (32 / n) * (2 * i + 1)) % 128;
    mm = m % 64;
    if (mm > 32) mm = 64 - mm;
    if (mm % 2 == 1)      mag = A32[(mm - 1) / 2];
    else if (mm % 4 == 2) mag = A16[(mm - 2) / 4];
    else if (mm % 8 == 4) mag = A8[(mm - 4) / 8];
    else if (mm % 16 == 8) mag = A4[(mm - 8) / 16];
    else if (mm == 16)    mag = 64;
    else                  mag = 0;
    c = $cos(3.141592653589793 * m / 64.0);
    return (c < 0.0) ? -mag : mag;
  endfunction

  function automatic exp_t model(input logic [1:0] s,
                                 input logic [32*IN_W-1:0] x);
    exp_t r;
    int n, acc, ev;
    int xv [32];
    int od [16];
    n = 4 << s;
    r.s = s;
    r.e = '0;
    r.o = '0;
    for (int i = 0; i < 32; i++) xv[i] = $signed(x[i*IN_W +: IN_W]);
    for (int i = 0; i < 16; i++) begin
      od[i] = 0;
      if (i < n / 2) begin
        ev = xv[i] + xv[n-1-i];
        od[i] = xv[i] - xv[n-1-i];
        r.e[i*EW +: EW] = EW'(ev);
      end
    end
    for (int k = 0; k < n / 2; k++) begin
      acc = 0;
      for (int i = 0; i < n / 2; i++) acc += tcoef(n, k, i) * od[i];
      r.o[k*YW +: YW] = YW'(acc);
    end
    return r;
  endfunction

  function automatic logic [32*IN_W-1:0] rand_x();
    logic [32*IN_W-1:0] v;
    for (int i = 0; i < 32; i++) v[i*IN_W +: IN_W] = IN_W'($urandom);
    return v;
  endfunction

  function automatic int yo(input int k);
    return int'($signed(out_o[k*YW +: YW]));
  endfunction

  function automatic int ev(input int k);
    return int'($signed(out_e[k*EW +: EW]));
  endfunction

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (scb.size() == 0) begin
        chk_i("unexpected_out", 1, 0);
      end else begin
        mon_ex = scb.pop_front();
        n_pop++;
        pop_cyc.push_back(cyc);
        chk_v("out_size", 512'(out_size), 512'(mon_ex.s));
        chk_v("out_e", 512'(out_e), 512'(mon_ex.e));
        chk_v("out_o", 512'(out_o), 512'(mon_ex.o));
      end
    end
  end

  task automatic send(input logic [1:0] s, input logic [32*IN_W-1:0] x);
    int t;
    t = 0;
    in_valid = 1'b1;
    in_size  = s;
    in_x     = x;
    scb.push_back(model(s, x));
    @(negedge clk);
    while (!in_ready && t < 2000) begin
      @(posedge clk);
      #1;
      if (rand_bp) begin
        out_ready = 1'($urandom_range(0, 1));
        in_size   = 2'($urandom);
        in_x      = rand_x();
        #1;
        if (in_ready) begin
          in_size = s;
          in_x    = x;
        end
      end
      @(negedge clk);
      t++;
    end
    if (!in_ready) chk_i("send_timeout", t, 0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (rand_bp) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_out(input string tag, input int lat);
    int k;
    k = 0;
    while (k < 20) begin
      @(negedge clk);
      k++;
      if (out_valid) break;
    end
    chk_i(tag, k, lat);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (scb.size() != 0 && t < 500) begin
      @(negedge clk);
      t++;
    end
    chk_i("drain", scb.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [32*IN_W-1:0] x;
    int base, stale;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_size   = '0;
    in_x      = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_i("rst_out_valid", int'(out_valid), 0);
    chk_v("rst_out_e", 512'(out_e), 512'(0));
    chk_v("rst_out_o", 512'(out_o), 512'(0));
    chk_i("rst_out_size", int'(out_size), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk_i("rst_in_ready", int'(in_ready), 1);

    x = '0;
    x[0 +: IN_W] = IN_W'(1);
    send(2'd3, x);
    wait_out("lat_imp32", 3);
    chk_i("imp_e0", ev(0), 1);
    chk_i("imp_e1", ev(1), 0);
    chk_i("imp_yo0", yo(0), 90);
    chk_i("imp_yo7", yo(7), 67);
    chk_i("imp_yo15", yo(15), 4);
    drain();

    for (int i = 0; i < 32; i++)
      x[i*IN_W +: IN_W] = (i < 16) ? IN_W'(-256) : IN_W'(255);
    send(2'd3, x);
    wait_out("lat_ext", 3);
    chk_i("ext_yo0", yo(0), -471142);
    chk_i("ext_e0", ev(0), -1);
    chk_i("ext_e15", ev(15), -1);
    drain();

    for (int i = 0; i < 32; i++) x[i*IN_W +: IN_W] = IN_W'(255);
    send(2'd3, x);
    wait_out("lat_255", 3);
    chk_i("all255_yo0", yo(0), 0);
    chk_i("all255_e9", ev(9), 510);
    drain();

    for (int i = 0; i < 32; i++)
      x[i*IN_W +: IN_W] = (i < 4) ? IN_W'(10 * (i + 1)) : IN_W'(100);
    send(2'd0, x);
    wait_out("lat_n4", 3);
    chk_i("n4_e0", ev(0), 50);
    chk_i("n4_e2", ev(2), 0);
    chk_i("n4_yo0", yo(0), -2850);
    chk_i("n4_yo1", yo(1), -250);
    chk_i("n4_yo2", yo(2), 0);
    chk_i("n4_size", int'(out_size), 0);
    drain();

    x = '0;
    x[0 +: IN_W] = IN_W'(1);
    base = pop_cyc.size();
    send(2'd1, x);
    send(2'd2, x);
    wait_out("lat_b2b", 2);
    chk_i("n8_yo0", yo(0), 89);
    chk_i("n8_yo3", yo(3), 18);
    chk_i("n8_yo4", yo(4), 0);
    @(negedge clk);
    chk_i("n16_valid", int'(out_valid), 1);
    chk_i("n16_size", int'(out_size), 2);
    chk_i("n16_yo0", yo(0), 90);
    chk_i("n16_yo7", yo(7), 9);
    drain();
    chk_i("b2b_gap", pop_cyc[base+1] - pop_cyc[base], 1);

    base = n_pop;
    out_ready = 1'b0;
    fork
      begin
        bp_t = 0;
        while (!out_valid && bp_t < 50) begin
          @(negedge clk);
          bp_t++;
        end
        hold_o = out_o;
        hold_e = out_e;
        hold_s = out_size;
        chk_i("bp_in_ready_low", int'(in_ready), 0);
        repeat (3) begin
          @(negedge clk);
          chk_i("bp_hold_valid", int'(out_valid), 1);
          chk_i("bp_hold_ready", int'(in_ready), 0);
          chk_v("bp_hold_o", 512'(out_o), 512'(hold_o));
          chk_v("bp_hold_e", 512'(out_e), 512'(hold_e));
          chk_i("bp_hold_s", int'(out_size), int'(hold_s));
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join_none
    for (int r = 0; r < 5; r++) send(2'(r), rand_x());
    drain();
    chk_i("bp_count", n_pop - base, 5);

    base = n_pop;
    rand_bp = 1'b1;
    for (int r = 0; r < 10000; r++) send(2'($urandom), rand_x());
    rand_bp = 1'b0;
    out_ready = 1'b1;
    drain();
    chk_i("rand_count", n_pop - base, 10000);

    out_ready = 1'b0;
    send(2'd3, rand_x());
    send(2'd2, rand_x());
    wait_out("rst_pre_valid", 2);
    #2;
    rst_n = 1'b0;
    #1;
    chk_i("arst_valid", int'(out_valid), 0);
    chk_v("arst_e", 512'(out_e), 512'(0));
    chk_v("arst_o", 512'(out_o), 512'(0));
    chk_i("arst_size", int'(out_size), 0);
    scb.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    chk_i("arst_in_ready", int'(in_ready), 1);
    stale = 0;
    repeat (8) begin
      @(negedge clk);
      stale += int'(out_valid);
    end
    chk_i("arst_no_stale", stale, 0);
    @(posedge clk);
    #1;
    send(2'd1, rand_x());
    wait_out("lat_post_rst", 3);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dct2_1d_stage1_pipe.md
Name: dct2_1d_stage1_pipe

Overview:
- Pipelined, size-configurable first stage of the 1-D DCT-II for the VVC transform path.
- Accepts one row of up to 32 residual samples per handshake, performs even/odd decomposition, and computes the odd-half outputs with the integer DCT-II coefficients for N = 4, 8, 16 or 32.
- The even half is passed downstream to the recursive even-part stages.
- Successor to the fixed 32-point combinational stage: it adds a selectable transform size, parametric width, valid/ready flow control and registered pipelining.

Parameters:
IN_W, 9, signed input sample width
PIPE_MUL, 1, 1 = register between multipliers and adder trees (latency 3); 0 = no such register (latency 2)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  row present on in_x
in_ready  out  1  stage can accept a row this cycle
in_size  in  2  transform size: 0=4, 1=8, 2=16, 3=32
in_x  in  32*IN_W  signed samples; X[i] = in_x[i*IN_W +: IN_W]
out_valid  out  1  result present
out_ready  in  1  downstream accepts result
out_size  out  2  in_size carried with the row
out_e  out  16*(IN_W+1)  signed even terms; E[i] at [i*(IN_W+1) +: IN_W+1]
out_o  out  16*(IN_W+11)  signed odd outputs; Yo[k] at [k*(IN_W+11) +: IN_W+11]

Behaviour:
- Clocking and reset:
  - Single clock.
  - rst_n low asynchronously clears all stage valids, all data registers and out_size. out_valid=0, out_e=0, out_o=0, out_size=0.
  - in_ready=1 after reset.
- Transfer rule: a row transfers on an edge where in_valid && in_ready; a result transfers where out_valid && out_ready.
- Decomposition, with N = 4<<in_size and H = N/2:
  - E[i] = X[i] + X[N-1-i] for i<H.
  - O[i] = X[i] - X[N-1-i] for i<H.
  - E[i]=0 and O[i]=0 for i>=H.
  - X[N..31] are ignored.
- Odd outputs:
  - Yo[k] = sum over i<H of C32[(2k+1)*(32/N)][i] * O[i], for k<H.
  - Yo[k]=0 for k>=H.
  - C32 is the standard VVC 32-point integer DCT-II matrix.
  - Anchors (column 0 of the odd rows):
    - N=32: 90,90,88,85,82,78,73,67,61,54,46,38,31,22,13,4
    - N=16: 90,87,80,70,57,43,25,9
    - N=8: 89,75,50,18
    - N=4: 83,36
  - Coefficients are held as a constant table (8-bit signed). No runtime ROM.
- Width rules:
  - E and O are IN_W+1 bits, exact.
  - Yo is IN_W+11 bits, exact: the largest row sum of |coeff| is 922 < 2^10, so no saturation or rounding is needed.
  - All arithmetic is signed, with sign-extension before each add.
- Pipeline (PIPE_MUL=1), three register stages:
  - A: E, O, size
  - B: 16x16 products, E, size
  - C: adder-tree sums, E, size, driving the outputs
  - PIPE_MUL=0 removes B.
  - Latency: out_valid rises LAT = 2+PIPE_MUL cycles after the accept cycle when unstalled.
  - Throughput: 1 row per cycle.
- Backpressure:
  - Each stage s holds when it is valid and the next stage is not ready.
  - ready_s = !valid_s || ready_{s+1}. Final-stage ready is out_ready.
  - in_ready = ready_A, combinational from the stage valids and out_ready. There is no combinational path from in_valid.
  - While stalled, out_* are held stable.
  - No row is dropped, duplicated or reordered.
- Size handling:
  - size travels with each row.
  - Rows of different sizes may be interleaved back-to-back with no bubble.
- Boundary conditions:
  - Simultaneous accept and emit on a full pipeline is allowed, giving full throughput.
  - in_size or in_x changing while in_valid && !in_ready has no effect.
  - Reset mid-operation discards all in-flight rows. Nothing from before the reset is emitted after rst_n releases.

Test Plan:
- Impulse, N=32, PIPE_MUL=1: X[0]=1, others 0.
  - out_e = E[0]=1, rest 0.
  - out_o = Yo = 90,90,88,85,82,78,73,67,61,54,46,38,31,22,13,4.
  - out_valid 3 cycles after the accept cycle.
- Extremes, N=32: X[0..15]=-256, X[16..31]=255.
  - E all -1, O all -511.
  - Yo[0] = -471142, which fits in 20 bits.
  - All X=255: O=0, all Yo=0, all E=510.
- N=4: X[0..3]=10,20,30,40, X[4..31]=100.
  - E[0..1]=50,50; O[0..1]=-30,-10.
  - Yo[0]=-2850, Yo[1]=-250.
  - All other E/Yo lanes 0; out_size=0.
- N=8 impulse (X[0]=1) followed back-to-back by N=16 impulse.
  - First result Yo[0..3]=89,75,50,18.
  - Second result Yo[0..7]=90,87,80,70,57,43,25,9, out_size=2.
  - Consecutive cycles.
- Backpressure: 5 back-to-back rows, out_ready low for 4 cycles from the first out_valid.
  - in_ready falls once 3 rows are resident.
  - Outputs held stable.
  - All 5 results emitted in order with no duplicates.
  - Random out_ready reference-model comparison over 10k rows.
- Reset mid-flight: drop rst_n with 2 rows in flight.
  - out_valid=0, outputs 0 immediately, asynchronous to clk.
  - After release, in_ready=1 and no stale result appears. A new row completes with the correct latency.
